serial_bin_subtractor: RTL and testbench
========================================

Name: serial_bin_subtractor

Overview:
- Multi-cycle, bit-serial N-bit binary subtractor computing Diff = A - B - Bin, one bit per clock, LSB first.
- Counterpart to the parallel parameterized ripple adder in the lab-exercise datapath: it subtracts instead of adding, sequentially instead of combinationally.
- Uses a start/busy/done handshake.
- Instantiated beside the adders in a top module at widths 4 and 8.

Parameters:
- n, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- A  input  n  minuend; captured on the accepted start edge
- B  input  n  subtrahend; captured on the accepted start edge
- Bin  input  1  borrow-in; captured on the accepted start edge
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results update
- Diff  output  n  result register
- Bout  output  1  borrow out of the MSB; 1 when A < B + Bin (unsigned)
- Ovf  output  1  two's-complement overflow of the signed subtraction

Behaviour:
- Reset, synchronous on a rst=1 clock edge:
  - state=IDLE, busy=0, done=0, Diff=0, Bout=0, Ovf=0.
  - Bit counter, shift registers and borrow register cleared.
  - rst has priority over start.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge k loads shA<=A, shB<=B, br<=Bin, cnt<=0, then goes to SHIFT.
  - busy=1 from cycle k+1.
- SHIFT, one bit per cycle:
  - d = shA[0]^shB[0]^br.
  - br_next = (~shA[0]&shB[0]) | (~(shA[0]^shB[0])&br).
  - d shifts into the MSB of the internal result shift register; shA and shB shift right; cnt increments.
  - When cnt = n-2, record br_prev = br, the borrow into the MSB.
  - After n SHIFT cycles, i.e. the cycle with cnt = n-1, go to DONE.
- DONE, exactly one cycle:
  - Diff, Bout=br and Ovf=br_prev^br are updated together at the DONE-entry edge.
  - done=1 and busy=0 during this cycle; the next state is IDLE.
- Latency: start accepted at edge k; done is high in the cycle after edge k+n; results are visible from that same cycle.
- Diff/Bout/Ovf hold their last values until the next DONE. They do not change at start acceptance or during SHIFT.
- start during SHIFT or DONE is ignored. Operands are not re-sampled.
- Operand inputs are don't-care except at the accepted start edge.
- Bin=1 with A=B produces Diff = all ones, Bout=1, Ovf=0.
- Reset mid-SHIFT aborts the operation: no done pulse, outputs return to 0, and the next start is accepted normally.
- Arithmetic is modulo 2^n. Bout equals the unsigned borrow; Ovf equals the signed overflow of A-B-Bin.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
  - the counter width function clog2(n)
- One natural sub-module, full_subtractor: 1-bit combinational, inputs a, b, bi; outputs d, bo. Instantiated once in the SHIFT datapath.
- Everything else stays in serial_bin_subtractor: FSM, counter, shift registers, result registers.

Test Plan:
- n=8, A=8'h3C, B=8'h15, Bin=0 -> Diff=8'h27, Bout=0, Ovf=0; done high exactly 9 cycles after the start edge; busy high for the 8 cycles before.
- n=8, A=8'h00, B=8'h01, Bin=0 -> Diff=8'hFF, Bout=1, Ovf=0. Then A=8'h05, B=8'h05, Bin=1 -> Diff=8'hFF, Bout=1, Ovf=0.
- n=8, A=8'h80, B=8'h01, Bin=0 -> Diff=8'h7F, Bout=0, Ovf=1. Then A=8'h7F, B=8'hFF -> Diff=8'h80, Bout=1, Ovf=1.
- n=8, start A=8'h10, B=8'h01, then pulse start with A=8'hFF, B=8'h00 during SHIFT -> second request ignored; Diff=8'h0F; exactly one done pulse.
- n=8, start A=8'h3C, B=8'h15, assert rst on the 4th SHIFT cycle -> busy=0, Diff=0, Bout=0, Ovf=0, no done pulse. A subsequent start with A=8'h02, B=8'h01 -> Diff=8'h01 after 9 cycles.
- n=4, A=4'h7, B=4'hF, Bin=0 -> Diff=4'h8, Bout=1, Ovf=1; done 5 cycles after start. Diff holds 4'h8 through 10 idle cycles.

Source files
------------

// File: rtl/serial_bin_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_bin_subtractor_pkg
// Description : Shared state encoding and width helper for the bit-serial
//               subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_bin_subtractor_pkg;

  // Controller state encoding; the 2-bit width leaves one spare code (3).
  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  // Ceiling log2. For value >= 2 this is the number of bits needed to
  // count 0 .. value-1, which is exactly what the bit counter must reach.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage : serial_bin_subtractor_pkg
`default_nettype wire

// File: rtl/serial_bin_subtractor_full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor
// Description : 1-bit combinational full subtractor, d = a - b - bi with
//               borrow out bo.
// Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  logic w_ab_diff;

  // Difference bit and borrow out of a single column.
  always_comb begin
    w_ab_diff = a ^ b;
    d         = w_ab_diff ^ bi;
    // Borrow when b exceeds a outright, or when they are equal and a
    // borrow is already propagating in from the column below.
    bo        = (~a & b) | (~w_ab_diff & bi);
  end

endmodule : full_subtractor
`default_nettype wire

// File: rtl/serial_bin_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_bin_subtractor
// Description : Bit-serial n-bit subtractor, Diff = A - B - Bin, one bit per
//               clock LSB first, with start/busy/done handshake. Produces the
//               unsigned borrow (Bout) and signed overflow (Ovf).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_bin_subtractor
  import serial_bin_subtractor_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  input  logic         Bin,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] Diff,
  output logic         Bout,
  output logic         Ovf
);

  localparam int c_CW = clog2(n);

  // Controller
  logic [1:0]      r_state;
  logic [c_CW-1:0] r_cnt;

  // Operand shift registers and running borrow
  logic [n-1:0]    r_sh_a;
  logic [n-1:0]    r_sh_b;
  logic            r_br;
  logic            r_br_prev;

  // Partial result: holds the n-1 bits produced so far; the final bit
  // comes straight from the full subtractor on the last SHIFT cycle.
  logic [n-2:0]    r_res;

  // Visible result registers
  logic [n-1:0]    r_diff;
  logic            r_bout;
  logic            r_ovf;

  // Datapath wires
  logic            w_d;
  logic            w_bo;
  logic [n-1:0]    w_res_next;
  logic            w_last;
  logic            w_msb_next;

  // Single column of the subtraction, fed from the operand LSBs.
  full_subtractor u_fs (
    .a  (r_sh_a[0]),
    .b  (r_sh_b[0]),
    .bi (r_br),
    .d  (w_d),
    .bo (w_bo)
  );

  // Result shift path and counter decodes.
  always_comb begin
    w_res_next = {w_d, r_res};
    w_last     = (r_cnt == c_CW'(n - 1));
    // Borrow produced at bit n-2 is the borrow into the MSB column.
    w_msb_next = (r_cnt == c_CW'(n - 2));
  end

  // Controller, serial datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_cnt     <= '0;
      r_sh_a    <= '0;
      r_sh_b    <= '0;
      r_br      <= 1'b0;
      r_br_prev <= 1'b0;
      r_res     <= '0;
      r_diff    <= '0;
      r_bout    <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_sh_a  <= A;
            r_sh_b  <= B;
            r_br    <= Bin;
            r_cnt   <= '0;
            r_state <= c_SHIFT;
          end
        end

        c_SHIFT: begin
          r_sh_a <= r_sh_a >> 1;
          r_sh_b <= r_sh_b >> 1;
          r_br   <= w_bo;
          r_res  <= w_res_next[n-1:1];
          r_cnt  <= r_cnt + c_CW'(1);
          if (w_msb_next) begin
            r_br_prev <= w_bo;
          end
          if (w_last) begin
            // All three results change together on entry to DONE;
            // overflow is borrow-in to the MSB xor borrow-out of it.
            r_diff  <= w_res_next;
            r_bout  <= w_bo;
            r_ovf   <= r_br_prev ^ w_bo;
            r_state <= c_DONE;
          end
        end

        c_DONE: begin
          r_state <= c_IDLE;
        end

        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Handshake outputs decode straight from the registered state.
  always_comb begin
    busy = (r_state == c_SHIFT);
    done = (r_state == c_DONE);
    Diff = r_diff;
    Bout = r_bout;
    Ovf  = r_ovf;
  end

endmodule : serial_bin_subtractor
`default_nettype wire

// File: tb/tb_serial_bin_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_bin_subtractor
// Description : Self-checking bench for serial_bin_subtractor at n=8 and n=4,
//               with an arithmetic reference model and directed cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_bin_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       s8, bin8, busy8, done8, bo8, ov8;
  logic [7:0] a8, b8, d8;
  logic       s4, bin4, busy4, done4, bo4, ov4;
  logic [3:0] a4, b4, d4;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  serial_bin_subtractor #(.n(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .A(a8), .B(b8), .Bin(bin8),
    .busy(busy8), .done(done8), .Diff(d8), .Bout(bo8), .Ovf(ov8)
  );

  serial_bin_subtractor #(.n(4)) dut4 (
    .clk(clk), .rst(rst), .start(s4), .A(a4), .B(b4), .Bin(bin4),
    .busy(busy4), .done(done4), .Diff(d4), .Bout(bo4), .Ovf(ov4)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {ovf, bout, diff}.
  function automatic logic [33:0] calc(input int w, input logic [31:0] a,
                                       input logic [31:0] b, input logic bin);
    longint mx, ua, ub, b1, sa, sb, r;
    logic [31:0] d;
    logic bout, ovf;
    mx = longint'(1) << w;
    ua = longint'(a);
    ub = longint'(b);
    b1 = bin ? 1 : 0;
    d    = 32'((ua - ub - b1 + mx) % mx);
    bout = (ua < ub + b1);
    sa = (ua >= mx / 2) ? ua - mx : ua;
    sb = (ub >= mx / 2) ? ub - mx : ub;
    r  = sa - sb - b1;
    ovf = (r < -(mx / 2)) || (r > mx / 2 - 1);
    return {ovf, bout, d};
  endfunction

  // Model: phase 0 idle, k>0 means k busy cycles remain, -1 is the done cycle.
  int          m_phase[2] = '{0, 0};
  logic [31:0] m_diff[2]  = '{0, 0};
  logic        m_bout[2]  = '{0, 0};
  logic        m_ovf[2]   = '{0, 0};
  logic [33:0] m_pend[2]  = '{0, 0};

  task automatic model_step(input int i, input int w, input logic st,
                            input logic [31:0] a, input logic [31:0] b, input logic bin);
    if (rst) begin
      m_phase[i] = 0;
      m_diff[i]  = 0;
      m_bout[i]  = 0;
      m_ovf[i]   = 0;
    end else if (m_phase[i] == 0) begin
      if (st) begin
        m_phase[i] = w;
        m_pend[i]  = calc(w, a, b, bin);
      end
    end else if (m_phase[i] == -1) begin
      m_phase[i] = 0;
    end else if (m_phase[i] == 1) begin
      m_phase[i] = -1;
      m_diff[i]  = m_pend[i][31:0];
      m_bout[i]  = m_pend[i][32];
      m_ovf[i]   = m_pend[i][33];
    end else begin
      m_phase[i] = m_phase[i] - 1;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 8, s8, {24'd0, a8}, {24'd0, b8}, bin8);
    model_step(1, 4, s4, {28'd0, a4}, {28'd0, b4}, bin4);
    if (rst) chk_en = 1'b1;
  end

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy8", {31'd0, busy8}, {31'd0, m_phase[0] > 0});
      check("done8", {31'd0, done8}, {31'd0, m_phase[0] == -1});
      check("diff8", {24'd0, d8}, m_diff[0]);
      check("bout8", {31'd0, bo8}, {31'd0, m_bout[0]});
      check("ovf8",  {31'd0, ov8}, {31'd0, m_ovf[0]});
      check("busy4", {31'd0, busy4}, {31'd0, m_phase[1] > 0});
      check("done4", {31'd0, done4}, {31'd0, m_phase[1] == -1});
      check("diff4", {28'd0, d4}, m_diff[1]);
      check("bout4", {31'd0, bo4}, {31'd0, m_bout[1]});
      check("ovf4",  {31'd0, ov4}, {31'd0, m_ovf[1]});
    end
  end

  function automatic logic f_done(input int i);
    return (i == 0) ? done8 : done4;
  endfunction
  function automatic logic f_busy(input int i);
    return (i == 0) ? busy8 : busy4;
  endfunction
  function automatic logic [7:0] f_diff(input int i);
    return (i == 0) ? d8 : {4'd0, d4};
  endfunction

  // Directed operation with literal expectations and latency checks.
  task automatic op(input int i, input logic [7:0] a, input logic [7:0] b, input logic bin,
                    input logic [7:0] ed, input logic ebo, input logic eov, input string nm);
    int lat, busy_cnt, w;
    bit seen;
    w = (i == 0) ? 8 : 4;
    @(negedge clk);
    if (i == 0) begin a8 = a; b8 = b; bin8 = bin; s8 = 1'b1; end
    else begin a4 = a[3:0]; b4 = b[3:0]; bin4 = bin; s4 = 1'b1; end
    @(negedge clk);
    s8 = 1'b0; s4 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
    lat = 1; busy_cnt = 0; seen = 1'b0;
    while (!seen && lat < 40) begin
      if (f_done(i)) seen = 1'b1;
      else begin
        if (f_busy(i)) busy_cnt++;
        @(negedge clk);
        lat++;
      end
    end
    check({nm, "_latency"}, lat, w + 1);
    check({nm, "_busycycles"}, busy_cnt, w);
    check({nm, "_diff"}, {24'd0, f_diff(i)}, {24'd0, ed});
    check({nm, "_bout"}, {31'd0, (i == 0) ? bo8 : bo4}, {31'd0, ebo});
    check({nm, "_ovf"},  {31'd0, (i == 0) ? ov8 : ov4}, {31'd0, eov});
  endtask

  initial begin
    int dcnt;
    rst = 1'b1;
    s8 = 0; a8 = 0; b8 = 0; bin8 = 0;
    s4 = 0; a4 = 0; b4 = 0; bin4 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", {31'd0, busy8}, 0);
    check("reset_done", {31'd0, done8}, 0);
    check("reset_diff", {24'd0, d8}, 0);

    op(0, 8'h3C, 8'h15, 1'b0, 8'h27, 1'b0, 1'b0, "sub_3c_15");
    op(0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "sub_00_01");
    op(0, 8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0, "sub_eq_bin");
    op(0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "sub_80_01");
    op(0, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "sub_7f_ff");

    // Second start during SHIFT must be ignored.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; bin8 = 0; s8 = 1;
    @(negedge clk);
    s8 = 0;
    repeat (2) @(negedge clk);
    a8 = 8'hFF; b8 = 8'h00; s8 = 1;
    @(negedge clk);
    s8 = 0;
    dcnt = 0;
    for (int k = 0; k < 15; k++) begin
      if (done8) dcnt++;
      @(negedge clk);
    end
    check("ignored_start_diff", {24'd0, d8}, 32'h0F);
    check("ignored_start_donecount", dcnt, 1);

    // Reset in the 4th SHIFT cycle aborts the operation.
    a8 = 8'h3C; b8 = 8'h15; bin8 = 0; s8 = 1;
    @(negedge clk);
    s8 = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_busy", {31'd0, busy8}, 0);
    check("abort_diff", {24'd0, d8}, 0);
    check("abort_bout", {31'd0, bo8}, 0);
    check("abort_ovf",  {31'd0, ov8}, 0);
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      if (done8) dcnt++;
      @(negedge clk);
    end
    check("abort_no_done", dcnt, 0);
    op(0, 8'h02, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0, "after_abort");

    // Narrow instance and result hold.
    op(1, 8'h07, 8'h0F, 1'b0, 8'h08, 1'b1, 1'b1, "n4_7_f");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("n4_hold", {28'd0, d4}, 32'h8);
    end

    // Random traffic on both instances, starts and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst  = ($urandom_range(0, 249) == 0);
      s8   = ($urandom_range(0, 2) == 0);
      a8   = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      s4   = ($urandom_range(0, 2) == 0);
      a4   = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
    end
    @(negedge clk);
    rst = 0; s8 = 0; s4 = 0;
    repeat (12) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_bin_subtractor
`default_nettype wire
